// File: rtl/l2r_exp_datapath_pkg.sv
// Shared definitions for the L2R exponentiation control unit and datapath.
package l2r_pkg;

   localparam int L2R_WIDTH = 8;

   // RegC source select codes driven on S_C
   localparam logic [1:0] SC_ONE  = 2'd0;
   localparam logic [1:0] SC_SQR  = 2'd1;
   localparam logic [1:0] SC_MUL  = 2'd2;
   localparam logic [1:0] SC_HOLD = 2'd3;

endpackage

// File: rtl/l2r_exp_datapath_if.sv
// Strobe/status bundle between the L2R control unit (master) and datapath (slave).
interface l2r_exp_datapath_if
   import l2r_pkg::*;
#(
   parameter int WIDTH = L2R_WIDTH
) ();

   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             LoadA;
   logic             LoadB;
   logic             ShiftB;
   logic             LoadC;
   logic [1:0]       S_C;
   logic             LoadCoun;
   logic             S_Coun;
   logic             equals;
   logic             prevRegB;
   logic [WIDTH-1:0] c_out;

   modport master (
      output a_in, b_in, LoadA, LoadB, ShiftB, LoadC, S_C, LoadCoun, S_Coun,
      input  equals, prevRegB, c_out
   );

   modport slave (
      input  a_in, b_in, LoadA, LoadB, ShiftB, LoadC, S_C, LoadCoun, S_Coun,
      output equals, prevRegB, c_out
   );

endinterface

// File: rtl/l2r_exp_datapath_counter.sv
// Bit counter with clear/increment that saturates at LIMIT and flags reaching it.
module l2r_counter #(
   parameter int LIMIT = 8,
   parameter int CW    = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic inc,
   output logic equals
);

   logic [CW-1:0] count;
   logic          at_limit;

   assign at_limit = (count == CW'(LIMIT));
   assign equals   = at_limit;

   // Increment stops at LIMIT so extra strobes from the controller never wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         if (!inc) begin
            count <= '0;
         end else if (!at_limit) begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/l2r_exp_datapath.sv
// L2R binary exponentiation datapath: C = A^B mod 2^WIDTH under control-unit strobes.
module l2r_exp_datapath
   import l2r_pkg::*;
#(
   parameter  int WIDTH = L2R_WIDTH,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   l2r_exp_datapath_if.slave  bus
);

   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] reg_c;
   logic             prev_b;
   logic [WIDTH-1:0] c_next;
   logic             cnt_equals;

   // A WIDTH-wide product context keeps exactly the low half of the full product
   function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      return x * y;
   endfunction

   always_comb begin
      c_next = reg_c;
      case (bus.S_C)
         SC_ONE:  c_next = WIDTH'(1);
         SC_SQR:  c_next = mul_mod(reg_c, reg_c);
         SC_MUL:  c_next = mul_mod(reg_c, reg_a);
         default: c_next = reg_c;
      endcase
   end

   // LoadB takes priority over ShiftB; C*A always sees the pre-edge RegA
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_a  <= '0;
         reg_b  <= '0;
         reg_c  <= '0;
         prev_b <= 1'b0;
      end else begin
         if (bus.LoadA) begin
            reg_a <= bus.a_in;
         end
         if (bus.LoadB) begin
            reg_b  <= bus.b_in;
            prev_b <= 1'b0;
         end else if (bus.ShiftB) begin
            reg_b  <= {reg_b[WIDTH-2:0], 1'b0};
            prev_b <= reg_b[WIDTH-1];
         end
         if (bus.LoadC) begin
            reg_c <= c_next;
         end
      end
   end

   l2r_counter #(
      .LIMIT (WIDTH),
      .CW    (CW)
   ) u_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.LoadCoun),
      .inc    (bus.S_Coun),
      .equals (cnt_equals)
   );

   assign bus.equals   = cnt_equals;
   assign bus.prevRegB = prev_b;
   assign bus.c_out    = reg_c;

endmodule

// File: tb/tb_l2r_exp_datapath.sv
// Directed bench for l2r_exp_datapath with a reference model feeding a scoreboard queue.
module tb_l2r_exp_datapath;
   import l2r_pkg::*;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] c;
      logic         prev;
      logic         eq;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   l2r_exp_datapath_if #(.WIDTH(W)) bus ();

   l2r_exp_datapath #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   logic [W-1:0] m_a, m_b, m_c;
   logic         m_prev;
   int           m_coun;
   logic [W-1:0] seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_a = '0; m_b = '0; m_c = '0; m_prev = 1'b0; m_coun = 0;
      sb_q.delete();
   endtask

   task automatic idle_inputs();
      bus.LoadA = 0; bus.LoadB = 0; bus.ShiftB = 0; bus.LoadC = 0;
      bus.S_C = SC_HOLD; bus.LoadCoun = 0; bus.S_Coun = 0;
   endtask

   // Drive one cycle of strobes at a falling edge, predict, then compare at the next falling edge
   task automatic step(input string tag, input logic la, input logic lb, input logic sb,
                       input logic lc, input logic [1:0] sc, input logic lcn, input logic scn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] n_a, n_b, n_c;
      logic         n_prev;
      int           n_coun;
      exp_t         e;
      bus.a_in = a; bus.b_in = b;
      bus.LoadA = la; bus.LoadB = lb; bus.ShiftB = sb; bus.LoadC = lc;
      bus.S_C = sc; bus.LoadCoun = lcn; bus.S_Coun = scn;
      n_a = la ? a : m_a;
      n_b = m_b; n_prev = m_prev;
      if (lb) begin
         n_b = b; n_prev = 1'b0;
      end else if (sb) begin
         n_b = m_b << 1; n_prev = m_b[W-1];
      end
      n_c = m_c;
      if (lc) begin
         case (sc)
            SC_ONE:  n_c = 1;
            SC_SQR:  n_c = m_c * m_c;
            SC_MUL:  n_c = m_c * m_a;
            default: n_c = m_c;
         endcase
      end
      n_coun = m_coun;
      if (lcn) n_coun = scn ? ((m_coun >= W) ? W : m_coun + 1) : 0;
      m_a = n_a; m_b = n_b; m_c = n_c; m_prev = n_prev; m_coun = n_coun;
      sb_q.push_back('{c: m_c, prev: m_prev, eq: (m_coun == W)});
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_c"},    32'(bus.c_out),    32'(e.c));
         check({tag, "_prev"}, 32'(bus.prevRegB), 32'(e.prev));
         check({tag, "_eq"},   32'(bus.equals),   32'(e.eq));
      end
   endtask

   task automatic do_bit(input int idx);
      step("shift", 0, 0, 1, 0, SC_HOLD, 0, 0, '0, '0);
      seen[W-1-idx] = bus.prevRegB;
      step("sqr", 0, 0, 0, 1, SC_SQR, 0, 0, '0, '0);
      if (m_prev) step("mul", 0, 0, 0, 1, SC_MUL, 0, 0, '0, '0);
      step("inc", 0, 0, 0, 0, SC_HOLD, 1, 1, '0, '0);
   endtask

   task automatic run_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp_c);
      seen = '0;
      step("init", 1, 1, 0, 1, SC_ONE, 1, 0, a, b);
      for (int i = 0; i < W; i++) do_bit(i);
      check("run_result", 32'(bus.c_out), 32'(exp_c));
      check("run_equals", 32'(bus.equals), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      bus.a_in = '0; bus.b_in = '0;
      model_reset();

      // Reset held with random strobes
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_c", 32'(bus.c_out), 32'd0);
         check("rst_prev", 32'(bus.prevRegB), 32'd0);
         check("rst_eq", 32'(bus.equals), 32'd0);
         bus.a_in = W'($urandom); bus.b_in = W'($urandom);
         {bus.LoadA, bus.LoadB, bus.ShiftB, bus.LoadC} = 4'($urandom);
         bus.S_C = 2'($urandom);
         {bus.LoadCoun, bus.S_Coun} = 2'($urandom);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      step("post_rst_idle", 0, 0, 0, 0, SC_HOLD, 0, 0, '0, '0);

      // Full run 3^5
      run_exp(8'd3, 8'd5, 8'd243);
      check("bits_of_5", 32'(seen), 32'd5);

      // Old A used when LoadA and C*A coincide; hold code keeps C
      step("c_one", 0, 0, 0, 1, SC_ONE, 0, 0, '0, '0);
      step("mul_old_a", 1, 0, 0, 1, SC_MUL, 0, 0, 8'd5, '0);
      check("mul_old_a_val", 32'(bus.c_out), 32'd3);
      step("hold", 0, 0, 0, 1, SC_HOLD, 0, 0, '0, '0);
      step("mul_new_a", 0, 0, 0, 1, SC_MUL, 0, 0, '0, '0);
      check("mul_new_a_val", 32'(bus.c_out), 32'd15);

      // Wrap-around results
      run_exp(8'd2, 8'd9, 8'd0);
      run_exp(8'd255, 8'd2, 8'd1);

      // LoadB beats ShiftB
      step("load_ff", 0, 1, 0, 0, SC_HOLD, 0, 0, '0, 8'hFF);
      step("shift_ff", 0, 0, 1, 0, SC_HOLD, 0, 0, '0, '0);
      step("loadb_shiftb", 0, 1, 1, 0, SC_HOLD, 0, 0, '0, 8'h80);
      check("loadb_prio_prev", 32'(bus.prevRegB), 32'd0);
      step("shift_80", 0, 0, 1, 0, SC_HOLD, 0, 0, '0, '0);
      check("msb_80", 32'(bus.prevRegB), 32'd1);
      for (int i = 0; i < W; i++) step("drain", 0, 0, 1, 0, SC_HOLD, 0, 0, '0, '0);
      check("drained", 32'(bus.prevRegB), 32'd0);

      // Counter saturation then clear
      step("cnt_clr", 0, 0, 0, 0, SC_HOLD, 1, 0, '0, '0);
      for (int i = 0; i < 10; i++) step("cnt_inc", 0, 0, 0, 0, SC_HOLD, 1, 1, '0, '0);
      check("cnt_sat_eq", 32'(bus.equals), 32'd1);
      step("cnt_clr2", 0, 0, 0, 0, SC_HOLD, 1, 0, '0, '0);
      check("cnt_clr_eq", 32'(bus.equals), 32'd0);

      // Reset mid-run after 4 bits of 3^5, then rerun
      step("init_abort", 1, 1, 0, 1, SC_ONE, 1, 0, 8'd3, 8'd5);
      for (int i = 0; i < 4; i++) do_bit(i);
      rst_n = 1'b0;
      #1;
      check("midrst_c", 32'(bus.c_out), 32'd0);
      check("midrst_eq", 32'(bus.equals), 32'd0);
      check("midrst_prev", 32'(bus.prevRegB), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      run_exp(8'd3, 8'd5, 8'd243);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
